// File: rtl/licznik_synchr_updown.sv
// Synchronous modulo-MODULO up/down counter with clamped parallel load, cascade tc and wrap pulse.
// Latency: q and wrap update one clk edge after the inputs are sampled; tc is combinational from en/up/q.
// Backpressure: none; the counter accepts a new command on every rising edge.
//
// Ports:
//   clk   - single clock, all state changes on the rising edge
//   reset - synchronous active-high reset (q <= 0, wrap <= 0), highest priority
//   en    - count enable, one step per edge while high
//   up    - direction, 1 = up, 0 = down; used on the same edge it is sampled
//   load  - synchronous parallel load, beats en; d above MODULO-1 is clamped
//   d     - parallel load value
//   q     - registered count, always within 0..MODULO-1
//   tc    - terminal count for cascading: en & next step wraps
//   wrap  - registered one-cycle pulse after each count-driven wrap-around
module licznik_synchr_updown #(
   parameter int WIDTH  = 4,
   parameter int MODULO = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             wrap
);

   // Largest legal count value; MODULO may equal 2^WIDTH, so subtract in int first.
   localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULO - 1);
   localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

   logic             at_max;
   logic             at_zero;
   logic [WIDTH-1:0] d_clamped;
   logic [WIDTH-1:0] q_next;
   logic             wrap_next;

   assign at_max    = (q == MAX_VAL);
   assign at_zero   = (q == '0);
   assign d_clamped = (d > MAX_VAL) ? MAX_VAL : d;

   // Cascade output deliberately ignores load and reset so a downstream stage
   // sees the counting condition only.
   assign tc = en & ((up & at_max) | (~up & at_zero));

   // Next-state: load beats count; a load never produces a wrap pulse, even
   // when it lands on the terminal value.
   always_comb begin
      q_next    = q;
      wrap_next = 1'b0;
      if (load) begin
         q_next = d_clamped;
      end else if (en) begin
         if (up) begin
            if (at_max) begin
               q_next    = '0;
               wrap_next = 1'b1;
            end else begin
               q_next = q + ONE;
            end
         end else begin
            if (at_zero) begin
               q_next    = MAX_VAL;
               wrap_next = 1'b1;
            end else begin
               q_next = q - ONE;
            end
         end
      end
   end

   // All bits of q and the wrap flag update together on one edge; reset also
   // discards any wrap that would otherwise have been flagged.
   always_ff @(posedge clk) begin
      if (reset) begin
         q    <= '0;
         wrap <= 1'b0;
      end else begin
         q    <= q_next;
         wrap <= wrap_next;
      end
   end

endmodule
